// File: rtl/accel_frame_packer_if.sv
// Bus between the SPI receive side / FIFO reader and the frame packer.
interface accel_frame_packer_if #(
    parameter int AW = 3
);
    logic          cs;
    logic [3:0]    byte_count;
    logic [9:0]    miso_data;
    logic          ten_bit;
    logic          rd_en;
    logic          clr_ovf;
    logic [47:0]   frame_dout;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          frame_err;
    logic          overflow;

    modport master (
        output cs, byte_count, miso_data, ten_bit, rd_en, clr_ovf,
        input  frame_dout, empty, full, level, frame_err, overflow
    );

    modport slave (
        input  cs, byte_count, miso_data, ten_bit, rd_en, clr_ovf,
        output frame_dout, empty, full, level, frame_err, overflow
    );
endinterface

// File: rtl/accel_frame_packer.sv
// Packs SPI receive bytes into signed 16-bit X/Y/Z frames and queues them in a FWFT FIFO.
// state | meaning: IDLE wait cs fall | SKIP drop cmd bytes | COLLECT fill axes | PUSH write frame
module accel_frame_packer #(
    parameter int SKIP_BYTES = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic                clk,
    input  logic                rst,
    accel_frame_packer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_COLLECT, S_PUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_cs_q;
    logic [3:0]      r_bc_q;
    logic [7:0]      r_skip_cnt;
    logic [2:0]      r_byte_idx;
    logic            r_mode;
    logic [15:0]     r_x, r_y, r_z;
    logic            r_frame_err;
    logic            r_overflow;
    logic [47:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_level;

    logic            w_cs_fall, w_cs_rise, w_strobe, w_mode, w_last, w_err;
    logic            w_full, w_empty, w_pop, w_wr, w_ovf_set;
    logic [15:0]     w_sext;

    assign w_cs_fall = r_cs_q & ~bus.cs;
    assign w_cs_rise = ~r_cs_q & bus.cs;
    // A byte arrives exactly when the counter steps down by one; reloads never match.
    assign w_strobe  = ~bus.cs & ~r_cs_q & (bus.byte_count == r_bc_q - 4'd1);
    assign w_mode    = (r_byte_idx == 3'd0) ? bus.ten_bit : r_mode;
    assign w_last    = w_mode ? (r_byte_idx == 3'd2) : (r_byte_idx == 3'd5);
    assign w_sext    = {{6{bus.miso_data[9]}}, bus.miso_data};

    assign w_full    = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop     = bus.rd_en & ~w_empty;
    assign w_wr      = (r_state == S_PUSH) & (~w_full | w_pop);
    assign w_ovf_set = (r_state == S_PUSH) & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cs_q  <= 1'b0;
            r_bc_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cs_q  <= bus.cs;
            r_bc_q  <= bus.byte_count;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_nxt = (SKIP_BYTES == 0) ? S_COLLECT : S_SKIP;
            end
            S_SKIP: begin
                if (w_cs_rise) w_state_nxt = S_IDLE;
                else if (w_strobe && r_skip_cnt == 8'd1) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_err       = (r_byte_idx != 3'd0);
                end else if (w_strobe && w_last) begin
                    w_state_nxt = S_PUSH;
                end
            end
            S_PUSH:  w_state_nxt = bus.cs ? S_IDLE : S_COLLECT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skip_cnt  <= '0;
            r_byte_idx  <= '0;
            r_mode      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_skip_cnt <= 8'(SKIP_BYTES);
                        r_byte_idx <= '0;
                    end
                end
                S_SKIP: begin
                    if (w_strobe) r_skip_cnt <= r_skip_cnt - 8'd1;
                end
                S_COLLECT: begin
                    if (w_cs_rise) begin
                        r_byte_idx <= '0;
                    end else if (w_strobe) begin
                        r_mode     <= w_mode;
                        r_byte_idx <= w_last ? 3'd0 : r_byte_idx + 3'd1;
                        if (w_mode) begin
                            case (r_byte_idx)
                                3'd0:    r_x <= w_sext;
                                3'd1:    r_y <= w_sext;
                                default: r_z <= w_sext;
                            endcase
                        end else begin
                            case (r_byte_idx)
                                3'd0:    r_x[7:0]  <= bus.miso_data[7:0];
                                3'd1:    r_x[15:8] <= bus.miso_data[7:0];
                                3'd2:    r_y[7:0]  <= bus.miso_data[7:0];
                                3'd3:    r_y[15:8] <= bus.miso_data[7:0];
                                3'd4:    r_z[7:0]  <= bus.miso_data[7:0];
                                default: r_z[15:8] <= bus.miso_data[7:0];
                            endcase
                        end
                    end
                end
                default: r_byte_idx <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= {r_z, r_y, r_x};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // A dropped frame in the same cycle as a clear leaves the flag set.
            if (w_ovf_set)        r_overflow <= 1'b1;
            else if (bus.clr_ovf) r_overflow <= 1'b0;
        end
    end

    assign bus.frame_dout = r_mem[r_rd_ptr];
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.level      = r_level;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_accel_frame_packer.sv
// Scoreboard bench: byte bursts feed a queue-based frame model; a monitor checks every FIFO pop.
module tb_accel_frame_packer;
    localparam int SKIP  = 1;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accel_frame_packer_if #(.AW(3)) bus();

    accel_frame_packer #(.SKIP_BYTES(SKIP), .FIFO_DEPTH(DEPTH), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          err_seen = 0;
    int          exp_err  = 0;
    bit          rd_auto  = 1'b0;
    bit          force_rd = 1'b0;
    bit          exp_ovf  = 1'b0;
    logic [47:0] exp_q[$];
    logic [9:0]  bq[$];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    // Reader: random pops when enabled, otherwise follows force_rd.
    initial begin
        bus.rd_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rd_en = rd_auto ? 1'($urandom_range(0, 1)) : force_rd;
        end
    end

    // Monitor: counts frame_err cycles and checks every popped head against the model.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (bus.frame_err) err_seen++;
            if (!rst && bus.rd_en && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: actual %h, expected no frame", bus.frame_dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", bus.frame_dout, e);
                end
            end
        end
    end

    task automatic model_push(input logic [47:0] f, input bit popping);
        if (!rd_auto && !popping && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(f);
    endtask

    task automatic drive_byte(input logic [9:0] d);
        @(posedge clk);
        #1;
        bus.miso_data  = d;
        bus.byte_count = bus.byte_count - 4'd1;
    endtask

    task automatic send_bq(input bit tenb, input bit chk_lat, input bit pop_last, input logic [3:0] start_bc);
        int          per;
        int          vals[6];
        logic [15:0] ax[3];
        per = tenb ? 3 : 6;
        @(posedge clk);
        #1;
        bus.ten_bit    = tenb;
        bus.byte_count = start_bc;
        bus.cs         = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            if (bus.byte_count == 4'd1) begin
                @(posedge clk);
                #1;
                bus.byte_count = 4'd15;
            end
            drive_byte(bq[i]);
            if (i >= SKIP) begin
                int p;
                p = (i - SKIP) % per;
                vals[p] = int'(bq[i]);
                if (p == per - 1) begin
                    for (int a = 0; a < 3; a++) begin
                        if (tenb) ax[a] = 16'((vals[a] >= 512) ? vals[a] - 1024 : vals[a]);
                        else      ax[a] = 16'((vals[2*a] % 256) + 256 * (vals[2*a+1] % 256));
                    end
                    model_push({ax[2], ax[1], ax[0]}, pop_last && (i == bq.size() - 1));
                    if (chk_lat && i == bq.size() - 1) begin
                        @(negedge clk);
                        chk("lat_empty_n0", 48'(bus.empty), 48'd1);
                        @(negedge clk);
                        chk("lat_empty_n1", 48'(bus.empty), 48'd1);
                        @(negedge clk);
                        chk("lat_empty_n2", 48'(bus.empty), 48'd0);
                        chk("lat_level_n2", 48'(bus.level), 48'd1);
                    end
                    if (pop_last && i == bq.size() - 1) begin
                        @(posedge clk);
                        #1;
                        force_rd = 1'b1;
                        @(posedge clk);
                        #1;
                        force_rd = 1'b0;
                    end
                end
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.cs = 1'b1;
        if (bq.size() > SKIP && ((bq.size() - SKIP) % per) != 0) exp_err++;
        repeat (3) @(posedge clk);
    endtask

    task automatic rand_bq(input int n);
        bq.delete();
        for (int k = 0; k < n; k++) bq.push_back(10'($urandom_range(0, 1023)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_auto = 1'b1;
        while ((exp_q.size() != 0 || !bus.empty) && n < 400) begin
            @(posedge clk);
            n++;
        end
        rd_auto = 1'b0;
        repeat (2) @(posedge clk);
        chk("drain_empty", 48'(bus.empty), 48'd1);
        chk("drain_queue", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        int e0;
        rst            = 1'b1;
        bus.cs         = 1'b1;
        bus.byte_count = 4'd0;
        bus.miso_data  = 10'd0;
        bus.ten_bit    = 1'b0;
        bus.clr_ovf    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 48'(bus.empty), 48'd1);
        chk("rst_full", 48'(bus.full), 48'd0);
        chk("rst_level", 48'(bus.level), 48'd0);
        chk("rst_dout", bus.frame_dout, 48'd0);
        chk("rst_err", 48'(bus.frame_err), 48'd0);
        chk("rst_ovf", 48'(bus.overflow), 48'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        bq = '{10'h0AA, 10'h034, 10'h012, 10'h078, 10'h056, 10'h0BC, 10'h09A};
        send_bq(1'b0, 1'b1, 1'b0, 4'd15);
        chk("t1_head", bus.frame_dout, 48'h9ABC_5678_1234);
        drain();

        bq = '{10'h0AA, 10'h3FF, 10'h001, 10'h200};
        send_bq(1'b1, 1'b0, 1'b0, 4'd15);
        chk("t2_head", bus.frame_dout, 48'hFE00_0001_FFFF);
        drain();

        e0 = err_seen;
        bq = '{10'h0AA, 10'h011, 10'h022, 10'h033};
        send_bq(1'b0, 1'b0, 1'b0, 4'd15);
        chk("t3_err_pulse", 48'(err_seen - e0), 48'd1);
        chk("t3_level", 48'(bus.level), 48'd0);
        bq = '{10'h0AA, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006};
        send_bq(1'b0, 1'b0, 1'b0, 4'd15);
        chk("t3_next_head", bus.frame_dout, 48'h0605_0403_0201);
        drain();

        for (int f = 1; f <= 9; f++) begin
            rand_bq(SKIP + 6);
            send_bq(1'b0, 1'b0, 1'b0, 4'd15);
            if (f == 8) begin
                chk("t4_full8", 48'(bus.full), 48'd1);
                chk("t4_level8", 48'(bus.level), 48'd8);
                chk("t4_noovf8", 48'(bus.overflow), 48'd0);
            end
        end
        chk("t4_ovf", 48'(bus.overflow), 48'd1);
        chk("t4_ovf_model", 48'(bus.overflow), 48'(exp_ovf));
        chk("t4_level9", 48'(bus.level), 48'd8);
        @(posedge clk);
        #1;
        bus.clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_ovf = 1'b0;
        exp_ovf     = 1'b0;
        chk("t4_clr_ovf", 48'(bus.overflow), 48'(exp_ovf));

        rand_bq(SKIP + 6);
        send_bq(1'b0, 1'b0, 1'b1, 4'd15);
        chk("t5_level", 48'(bus.level), 48'd8);
        chk("t5_noovf", 48'(bus.overflow), 48'd0);
        chk("t5_head", bus.frame_dout, exp_q[0]);
        drain();

        rand_bq(SKIP + 12);
        send_bq(1'b0, 1'b0, 1'b0, 4'd8);
        chk("t6_level2", 48'(bus.level), 48'd2);
        drain();

        e0 = err_seen;
        @(posedge clk);
        #1;
        bus.ten_bit    = 1'b0;
        bus.byte_count = 4'd15;
        bus.cs         = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_byte(10'($urandom_range(0, 1023)));
            repeat (2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_empty", 48'(bus.empty), 48'd1);
        chk("t6_rst_level", 48'(bus.level), 48'd0);
        chk("t6_rst_dout", bus.frame_dout, 48'd0);
        chk("t6_rst_err", 48'(bus.frame_err), 48'd0);
        chk("t6_rst_ovf", 48'(bus.overflow), 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_byte(10'($urandom_range(0, 1023)));
            repeat (2) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        bus.cs = 1'b1;
        repeat (4) @(posedge clk);
        chk("t6_ignored_level", 48'(bus.level), 48'd0);
        chk("t6_ignored_empty", 48'(bus.empty), 48'd1);
        chk("t6_no_err", 48'(err_seen - e0), 48'd0);

        rd_auto = 1'b1;
        for (int b = 0; b < 25; b++) begin
            bit tenb;
            int per, nfr, extra;
            tenb  = 1'($urandom_range(0, 1));
            per   = tenb ? 3 : 6;
            nfr   = $urandom_range(0, 2);
            extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, per - 1) : 0;
            rand_bq(SKIP + nfr * per + extra);
            send_bq(tenb, 1'b0, 1'b0, 4'($urandom_range(3, 15)));
        end
        drain();
        chk("err_count", 48'(err_seen), 48'(exp_err));
        chk("final_ovf", 48'(bus.overflow), 48'(exp_ovf));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
